// File: rtl/ttrng_pkg.sv
// Shared constants for the TTRNG conditioner: Von Neumann pair layout, whitening LFSR
// definition and the legal parameter ranges of the conditioner.
package ttrng_pkg;

  // A raw byte is split into VN_PAIRS pairs; pair i is (raw[2i+1], raw[2i]) and pair 0 is
  // consumed first. When the two bits differ, the high bit of the pair is emitted.
  localparam int unsigned VN_PAIRS = 4;

  // Fibonacci LFSR x^8 + x^6 + x^5 + x^4 + 1, shifting left, feedback into bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  // Legal configuration ranges (DEPTH must also be a power of two).
  localparam int unsigned DEPTH_MIN     = 2;
  localparam int unsigned DEPTH_MAX     = 16;
  localparam int unsigned REP_LIMIT_MIN = 2;
  localparam int unsigned REP_LIMIT_MAX = 255;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ttrng_fifo.sv
// Synchronous FIFO for conditioned bytes. A push into a full FIFO is accepted only when a pop
// happens on the same edge, so occupancy stays exact at 0..DEPTH.
module ttrng_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/ttrng_conditioner.sv
// TTRNG raw-sample conditioner: Von Neumann debiasing, LSB-first byte packing, repetition-count
// health test and a small output FIFO on a valid/ready port.
// Optional build macro TTRNG_COND_MIX_EN: XOR each pushed byte with an 8-bit LFSR.
module ttrng_conditioner
  import ttrng_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   raw_valid,
  input  logic [7:0]             raw_data,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic                   health_fail,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  logic [7:0]  acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  prev_q, prev_d;
  logic [7:0]  rep_q, rep_d;
  logic        fail_q, fail_d;
  logic [7:0]  drop_q, drop_d;

  logic [3:0]  hi, lo;
  logic [15:0] ext;
  logic [3:0]  pos;
  logic        byte_done;
  logic [7:0]  push_data;
  logic        push_req, push_ok, drop_evt;
  logic        fifo_full, fifo_empty, pop;

  assign hi = {raw_data[7], raw_data[5], raw_data[3], raw_data[1]};
  assign lo = {raw_data[6], raw_data[4], raw_data[2], raw_data[0]};

  // Insert the surviving Von Neumann bits at acc[count] in pair order; pos ends at count+k.
  always_comb begin
    ext = {8'h00, acc_q};
    pos = {1'b0, cnt_q};
    if (hi[0] != lo[0]) begin ext[pos] = hi[0]; pos = pos + 4'd1; end
    if (hi[1] != lo[1]) begin ext[pos] = hi[1]; pos = pos + 4'd1; end
    if (hi[2] != lo[2]) begin ext[pos] = hi[2]; pos = pos + 4'd1; end
    if (hi[3] != lo[3]) begin ext[pos] = hi[3]; pos = pos + 4'd1; end
  end

  assign byte_done = raw_valid && pos[3];
  assign pop       = out_ready && !fifo_empty;
  assign push_req  = byte_done && !fail_q;
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop_evt  = push_req && fifo_full && !pop;

  // Accumulator, repetition test and drop counter next-state.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prev_d = prev_q;
    rep_d  = rep_q;
    fail_d = fail_q;
    drop_d = drop_q;
    if (raw_valid) begin
      prev_d = raw_data;
      if (raw_data == prev_q) rep_d = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
      else                    rep_d = 8'd0;
      if (rep_d == 8'(REP_LIMIT)) fail_d = 1'b1;
      // Completed byte leaves acc; the up-to-3-bit remainder restarts at bit 0.
      acc_d = pos[3] ? {5'b0, ext[10:8]} : ext[7:0];
      cnt_d = pos[2:0];
    end
    if (fail_q) begin
      acc_d = 8'h00;
      cnt_d = 3'd0;
    end
    if (drop_evt && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Conditioner state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= 8'h00;
      cnt_q  <= 3'd0;
      prev_q <= 8'h00;
      rep_q  <= 8'd0;
      fail_q <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
      rep_q  <= rep_d;
      fail_q <= fail_d;
      drop_q <= drop_d;
    end
  end

`ifdef TTRNG_COND_MIX_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Whitening LFSR advances only when a byte actually enters the FIFO.
  always_comb begin
    lfsr_d = push_ok ? lfsr_step(lfsr_q) : lfsr_q;
  end

  // Whitening LFSR register.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign push_data = ext[7:0] ^ lfsr_q;
`else
  assign push_data = ext[7:0];
`endif

  ttrng_fifo #(
    .DEPTH (DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (push_data),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid   = !fifo_empty;
  assign health_fail = fail_q;
  assign drop_count  = drop_q;

endmodule
